// File: rtl/recursive_ma_fir_pkg.sv
// Shared constants, sample/accumulator types and the divide-by-TAPS scaling helper.
// Macro RECURSIVE_MA_FIR_ROUND_EN selects round-half-up scaling instead of truncation.
`default_nettype none

package recursive_ma_fir_pkg;

    localparam int DATA_W    = 16;
    localparam int TAPS_LOG2 = 3;
    localparam int TAPS      = 2 ** TAPS_LOG2;
    localparam int ACC_W     = DATA_W + TAPS_LOG2;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [ACC_W:0]    acc_r_t;

    localparam acc_r_t SAMPLE_MAX = acc_r_t'((2 ** (DATA_W - 1)) - 1);
    localparam acc_r_t SAMPLE_MIN = acc_r_t'(-(2 ** (DATA_W - 1)));

    function automatic sample_t avg_scale(input acc_t a);
`ifdef RECURSIVE_MA_FIR_ROUND_EN
        acc_r_t t;
        t = acc_r_t'(a) + acc_r_t'(2 ** (TAPS_LOG2 - 1));
        t = t >>> TAPS_LOG2;
        if (t > SAMPLE_MAX) begin
            t = SAMPLE_MAX;
        end else if (t < SAMPLE_MIN) begin
            t = SAMPLE_MIN;
        end
        return sample_t'(t);
`else
        // Arithmetic shift truncates toward -inf; a sum of TAPS samples always fits.
        return sample_t'(a >>> TAPS_LOG2);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/ma_delay_line.sv
// TAPS-word sample shift register with synchronous clear; every tap is exposed.
`default_nettype none

module ma_delay_line
    import recursive_ma_fir_pkg::*;
#(
    parameter int N_TAPS = TAPS
) (
    input  logic    clk,
    input  logic    reset,
    input  sample_t d_i,
    output sample_t taps_o [N_TAPS]
);

    sample_t x_q [N_TAPS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_TAPS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            x_q[0] <= d_i;
            for (int i = 1; i < N_TAPS; i++) begin
                x_q[i] <= x_q[i-1];
            end
        end
    end

    assign taps_o = x_q;

endmodule

`default_nettype wire

// File: rtl/recursive_ma_fir_dual.sv
// Dual 8-tap moving average: direct adder-tree form and recursive acc form, bit-exact equal.
// Macro RECURSIVE_MA_FIR_ROUND_EN selects round-half-up output scaling.
`default_nettype none

module recursive_ma_fir_dual
    import recursive_ma_fir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic signed [DATA_W-1:0] d,
    output logic signed [DATA_W-1:0] q_8tap,
    output logic signed [DATA_W-1:0] q_rma
);

    sample_t taps [TAPS];
    acc_t    tree_sum;
    acc_t    acc_q;
    acc_t    acc_d;
    sample_t q_8tap_q;
    sample_t q_rma_q;

    ma_delay_line #(
        .N_TAPS (TAPS)
    ) u_delay_line (
        .clk    (clk),
        .reset  (reset),
        .d_i    (d),
        .taps_o (taps)
    );

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            tree_sum = tree_sum + acc_t'(taps[i]);
        end
    end

    // Exact integer update: the oldest tap is the one about to fall off the line.
    always_comb begin
        acc_d = acc_q + acc_t'(d) - acc_t'(taps[TAPS-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            q_8tap_q <= '0;
            q_rma_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            q_8tap_q <= avg_scale(tree_sum);
            q_rma_q  <= avg_scale(acc_q);
        end
    end

    assign q_8tap = q_8tap_q;
    assign q_rma  = q_rma_q;

endmodule

`default_nettype wire

// File: tb/tb_recursive_ma_fir_dual.sv
// Self-checking bench for recursive_ma_fir_dual: directed table plus model-checked streams.
`default_nettype none

module tb_recursive_ma_fir_dual;

    logic               clk;
    logic               reset;
    logic signed [15:0] d;
    logic signed [15:0] q_8tap;
    logic signed [15:0] q_rma;

    int n_checks;
    int n_fail;

    int win [8];
    int exp_q;
    int exp_acc;

    typedef struct {
        logic               rst;
        logic signed [15:0] din;
        int                 exp;
    } vec_t;

    vec_t tbl [$];

    recursive_ma_fir_dual dut (
        .clk    (clk),
        .reset  (reset),
        .d      (d),
        .q_8tap (q_8tap),
        .q_rma  (q_rma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int scale(input int s);
        int v;
`ifdef RECURSIVE_MA_FIR_ROUND_EN
        v = (s + 4) >>> 3;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`else
        v = s >>> 3;
`endif
        return v;
    endfunction

    function automatic int pick(input int trunc_v, input int round_v);
`ifdef RECURSIVE_MA_FIR_ROUND_EN
        return round_v;
`else
        return trunc_v;
`endif
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Drives one sample, advances one edge and updates the golden window model.
    task automatic step(input logic rst, input logic signed [15:0] din);
        int s;
        @(negedge clk);
        reset = rst;
        d     = din;
        @(posedge clk);
        s = 0;
        for (int i = 0; i < 8; i++) s += win[i];
        if (rst) begin
            for (int i = 0; i < 8; i++) win[i] = 0;
            exp_q = 0;
        end else begin
            exp_q = scale(s);
            for (int i = 7; i > 0; i--) win[i] = win[i-1];
            win[0] = int'(din);
        end
        exp_acc = 0;
        for (int i = 0; i < 8; i++) exp_acc += win[i];
        #1;
    endtask

    task automatic step_check(input logic rst, input logic signed [15:0] din, input string name);
        step(rst, din);
        check({name, " q_8tap"}, int'(q_8tap), exp_q);
        check({name, " q_rma"}, int'(q_rma), exp_q);
        check({name, " acc"}, int'(dut.acc_q), exp_acc);
    endtask

    task automatic add(input logic rst, input int din, input int expv);
        vec_t v;
        v.rst = rst;
        v.din = 16'(din);
        v.exp = expv;
        tbl.push_back(v);
    endtask

    initial begin
        int peak;
        int sv;
        real pi;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        d        = '0;
        pi       = 3.14159265358979;
        for (int i = 0; i < 8; i++) win[i] = 0;

        // Step to full scale, mid-step reset, impulse, negative full scale.
        add(1, 0, 0);
        add(0, 32767, 0);
        add(0, 32767, pick(4095, 4096));
        add(0, 32767, pick(8191, 8192));
        add(0, 32767, pick(12287, 12288));
        add(0, 32767, pick(16383, 16384));
        add(0, 32767, 20479);
        add(0, 32767, 24575);
        add(0, 32767, 28671);
        add(0, 32767, 32767);
        add(0, 32767, 32767);
        add(0, 32767, 32767);
        add(1, 32767, 0);
        add(0, 0, 0);
        add(0, 32767, 0);
        for (int k = 0; k < 8; k++) add(0, 0, pick(4095, 4096));
        add(0, 0, 0);
        add(0, 0, 0);
        add(0, -32768, 0);
        for (int k = 1; k <= 8; k++) add(0, -32768, -4096 * k);
        add(0, -32768, -32768);

        for (int n = 0; n < tbl.size(); n++) begin
            step(tbl[n].rst, tbl[n].din);
            check($sformatf("vec%0d q_8tap", n), int'(q_8tap), tbl[n].exp);
            check($sformatf("vec%0d q_rma", n), int'(q_rma), tbl[n].exp);
        end

        // Reset then a quiet input.
        step_check(1'b1, 16'sd0, "zero_rst");
        for (int n = 0; n < 20; n++) step_check(1'b0, 16'sd0, "zero_hold");

        // Low-frequency sine.
        for (int n = 0; n < 1024; n++) begin
            sv = $rtoi(20000.0 * $sin(2.0 * pi * n / 256.0));
            step_check(1'b0, 16'(sv), "sine_lf");
        end

        // Quarter-rate sine sits in a boxcar null: output should be tiny.
        peak = 0;
        for (int n = 0; n < 1024; n++) begin
            sv = $rtoi(20000.0 * $sin(2.0 * pi * n / 4.0 + 0.3));
            step_check(1'b0, 16'(sv), "sine_hf");
            if (n > 16 && (int'(q_8tap) > peak)) peak = int'(q_8tap);
            if (n > 16 && (-int'(q_8tap) > peak)) peak = -int'(q_8tap);
        end
        n_checks++;
        if (peak > 1000) begin
            n_fail++;
            $display("FAIL hf_atten: got peak %0d expected at most 1000", peak);
        end

        // Noisy sine.
        for (int n = 0; n < 1024; n++) begin
            sv = $rtoi(20000.0 * $sin(2.0 * pi * n / 64.0)) + int'($urandom_range(4000)) - 2000;
            step_check(1'b0, 16'(sv), "sine_noisy");
        end

        // Random samples with occasional reset pulses.
        for (int n = 0; n < 10000; n++) begin
            step_check(($urandom_range(99) == 0), 16'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
